// File: rtl/operand_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// operand_fetch_stage_if
//   Bundles the IFID-side inputs, the forwarding buses, the load-use hazard
//   inputs and the IDEX register outputs of operand_fetch_stage.
//
//   master : the surrounding pipeline (drives IFID, forwarding, flush, ready)
//   slave  : operand_fetch_stage (drives ifid_stall and the IDEX register)
//
//   Signals
//     ifid_valid, ifid_instr        IFID register contents
//     rf_ra_data, rf_rb_data        async register-file reads (src_a and rb)
//     fwd_ex_*, fwd_mem_*           EX / MEM forwarding buses
//     ex_load_pending, ex_load_reg  load currently in EX and its destination
//     flush, idex_ready             flush request, execute-stage accept
//     ifid_stall                    hold PC and IFID
//     idex_*                        registered IDEX contents
// ----------------------------------------------------------------------------
interface operand_fetch_stage_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
);
    logic              ifid_valid;
    logic [7:0]        ifid_instr;
    logic [DATA_W-1:0] rf_ra_data;
    logic [DATA_W-1:0] rf_rb_data;
    logic              fwd_ex_valid;
    logic [REG_AW-1:0] fwd_ex_reg;
    logic [DATA_W-1:0] fwd_ex_data;
    logic              fwd_mem_valid;
    logic [REG_AW-1:0] fwd_mem_reg;
    logic [DATA_W-1:0] fwd_mem_data;
    logic              ex_load_pending;
    logic [REG_AW-1:0] ex_load_reg;
    logic              flush;
    logic              idex_ready;
    logic              ifid_stall;
    logic              idex_valid;
    logic [3:0]        idex_opcode;
    logic [REG_AW-1:0] idex_ra;
    logic [REG_AW-1:0] idex_rb;
    logic [DATA_W-1:0] idex_op_a;
    logic [DATA_W-1:0] idex_op_b;

    modport master (
        output ifid_valid, ifid_instr, rf_ra_data, rf_rb_data,
               fwd_ex_valid, fwd_ex_reg, fwd_ex_data,
               fwd_mem_valid, fwd_mem_reg, fwd_mem_data,
               ex_load_pending, ex_load_reg, flush, idex_ready,
        input  ifid_stall, idex_valid, idex_opcode, idex_ra, idex_rb,
               idex_op_a, idex_op_b
    );

    modport slave (
        input  ifid_valid, ifid_instr, rf_ra_data, rf_rb_data,
               fwd_ex_valid, fwd_ex_reg, fwd_ex_data,
               fwd_mem_valid, fwd_mem_reg, fwd_mem_data,
               ex_load_pending, ex_load_reg, flush, idex_ready,
        output ifid_stall, idex_valid, idex_opcode, idex_ra, idex_rb,
               idex_op_a, idex_op_b
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// ----------------------------------------------------------------------------
// operand_fetch_stage
//   Decode-side operand fetch for the 8-bit Harvard pipeline. Resolves each
//   source operand from the EX forward bus, the MEM forward bus or the
//   register file (newest first), inserts one bubble per load-use hazard and
//   registers the result into IDEX.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     bus          operand_fetch_stage_if.slave (IFID in, forwarding in,
//                  ifid_stall out, IDEX register out)
//   Optional (macro OPERAND_FETCH_STALL_CNT_EN)
//     cnt_clr      synchronous clear of both counters
//     stall_cnt    saturating count of load-use bubbles inserted
//     bp_cnt       saturating count of backpressure (~advance) cycles
//
//   The register file is addressed with src_a (SP for PUSH/POP) outside
//   this block; rf_ra_data is expected to be that read.
// ----------------------------------------------------------------------------
module operand_fetch_stage #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    operand_fetch_stage_if.slave  bus
`ifdef OPERAND_FETCH_STALL_CNT_EN
    ,
    input  logic                  cnt_clr,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           bp_cnt
`endif
);

    localparam logic [REG_AW-1:0] SP_REG = REG_AW'(3);

    typedef enum logic {RUN, STALL} state_t;

    state_t            state;
    logic [3:0]        opcode;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] src_a;
    logic              is_push_pop;
    logic              is_in;
    logic              uses_a;
    logic              uses_b;
    logic              haz;
    logic              advance;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Newest-value selection; EX is younger than MEM so it wins on a tie.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] rf_data,
        input logic              ex_v,
        input logic [REG_AW-1:0] ex_r,
        input logic [DATA_W-1:0] ex_d,
        input logic              mem_v,
        input logic [REG_AW-1:0] mem_r,
        input logic [DATA_W-1:0] mem_d
    );
        if (ex_v && ex_r == src)        return ex_d;
        else if (mem_v && mem_r == src) return mem_d;
        else                            return rf_data;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch,
        // so no path can leave a value unassigned and infer a latch.
        uses_a      = 1'b0;
        opcode      = bus.ifid_instr[7:4];
        ra          = REG_AW'(bus.ifid_instr[3:2]);
        rb          = REG_AW'(bus.ifid_instr[1:0]);
        is_push_pop = (opcode == 4'h7) && (ra == REG_AW'(0) || ra == REG_AW'(1));
        is_in       = (opcode == 4'h7) && (ra == REG_AW'(3));
        src_a       = is_push_pop ? SP_REG : ra;

        unique case (opcode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'hA, 4'hD, 4'hE: uses_a = 1'b1;
            default:                                  uses_a = is_push_pop;
        endcase
        uses_b = !((opcode == 4'h0) || (opcode == 4'hC) || is_in);

        op_a = resolve(src_a, bus.rf_ra_data,
                       bus.fwd_ex_valid, bus.fwd_ex_reg, bus.fwd_ex_data,
                       bus.fwd_mem_valid, bus.fwd_mem_reg, bus.fwd_mem_data);
        op_b = resolve(rb, bus.rf_rb_data,
                       bus.fwd_ex_valid, bus.fwd_ex_reg, bus.fwd_ex_data,
                       bus.fwd_mem_valid, bus.fwd_mem_reg, bus.fwd_mem_data);

        // In STALL the load has moved to MEM, so its value is forwardable.
        haz = bus.ifid_valid && bus.ex_load_pending && (state == RUN) &&
              ((uses_a && bus.ex_load_reg == src_a) ||
               (uses_b && bus.ex_load_reg == rb));

        advance = bus.idex_ready || !bus.idex_valid;
    end

    // Stall is masked during reset and flush so the front end never holds a
    // stale instruction across either event.
    assign bus.ifid_stall = rst_n && !bus.flush && (haz || !advance);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            bus.idex_valid  <= 1'b0;
            bus.idex_opcode <= '0;
            bus.idex_ra     <= '0;
            bus.idex_rb     <= '0;
            bus.idex_op_a   <= '0;
            bus.idex_op_b   <= '0;
        end else if (bus.flush) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state           <= RUN;
            bus.idex_valid  <= 1'b0;
            bus.idex_opcode <= '0;
            bus.idex_ra     <= '0;
            bus.idex_rb     <= '0;
        end else if (advance) begin
            if (haz) begin
                // Bubble: NOP encoding; operand fields are don't-care and hold.
                state           <= STALL;
                bus.idex_valid  <= 1'b0;
                bus.idex_opcode <= '0;
                bus.idex_ra     <= '0;
                bus.idex_rb     <= '0;
            end else begin
                state           <= RUN;
                bus.idex_valid  <= bus.ifid_valid;
                bus.idex_opcode <= opcode;
                bus.idex_ra     <= ra;
                bus.idex_rb     <= rb;
                bus.idex_op_a   <= op_a;
                bus.idex_op_b   <= op_b;
            end
        end
        // ~advance: IDEX and state hold.
    end

`ifdef OPERAND_FETCH_STALL_CNT_EN
    logic bubble_ins;
    assign bubble_ins = !bus.flush && advance && haz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            bp_cnt    <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            bp_cnt    <= '0;
        end else begin
            if (bubble_ins && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (!advance && bp_cnt != 16'hFFFF)      bp_cnt    <= bp_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_operand_fetch_stage
//   Directed bench for operand_fetch_stage. Expected IDEX contents are pushed
//   to a scoreboard queue when an instruction is presented and popped when
//   IDEX reports a valid instruction.
// ----------------------------------------------------------------------------
module tb_operand_fetch_stage;

    typedef struct packed {
        logic [3:0] opc;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total_cnt;
    int   fail_cnt;
    exp_t sb[$];

    operand_fetch_stage_if #(.DATA_W(8), .REG_AW(2)) bus_if ();

`ifdef OPERAND_FETCH_STALL_CNT_EN
    logic        cnt_clr;
    logic [15:0] stall_cnt;
    logic [15:0] bp_cnt;
`endif

    operand_fetch_stage #(.DATA_W(8), .REG_AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
`ifdef OPERAND_FETCH_STALL_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .bp_cnt    (bp_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp)
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] instr, input logic [7:0] rfa, input logic [7:0] rfb);
        bus_if.ifid_valid = 1'b1;
        bus_if.ifid_instr = instr;
        bus_if.rf_ra_data = rfa;
        bus_if.rf_rb_data = rfb;
    endtask

    task automatic set_ex(input logic v, input logic [1:0] r, input logic [7:0] d);
        bus_if.fwd_ex_valid = v;
        bus_if.fwd_ex_reg   = r;
        bus_if.fwd_ex_data  = d;
    endtask

    task automatic set_mem(input logic v, input logic [1:0] r, input logic [7:0] d);
        bus_if.fwd_mem_valid = v;
        bus_if.fwd_mem_reg   = r;
        bus_if.fwd_mem_data  = d;
    endtask

    task automatic push(input logic [3:0] opc, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e = '{opc: opc, ra: ra, rb: rb, a: a, b: b};
        sb.push_back(e);
    endtask

    task automatic expect_issue(input string tag);
        exp_t e;
        check({tag, ".valid"}, 16'(bus_if.idex_valid), 16'd1);
        if (sb.size() == 0) begin
            total_cnt++;
            fail_cnt++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".opcode"}, 16'(bus_if.idex_opcode), 16'(e.opc));
            check({tag, ".ra"},     16'(bus_if.idex_ra),     16'(e.ra));
            check({tag, ".rb"},     16'(bus_if.idex_rb),     16'(e.rb));
            check({tag, ".op_a"},   16'(bus_if.idex_op_a),   16'(e.a));
            check({tag, ".op_b"},   16'(bus_if.idex_op_b),   16'(e.b));
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".valid"},  16'(bus_if.idex_valid),  16'd0);
        check({tag, ".opcode"}, 16'(bus_if.idex_opcode), 16'd0);
        check({tag, ".ra"},     16'(bus_if.idex_ra),     16'd0);
        check({tag, ".rb"},     16'(bus_if.idex_rb),     16'd0);
    endtask

    initial begin
        total_cnt = 0;
        fail_cnt  = 0;
        rst_n     = 1'b0;
        bus_if.ifid_valid      = 1'b0;
        bus_if.ifid_instr      = 8'h00;
        bus_if.rf_ra_data      = 8'h00;
        bus_if.rf_rb_data      = 8'h00;
        bus_if.ex_load_pending = 1'b0;
        bus_if.ex_load_reg     = 2'd0;
        bus_if.flush           = 1'b0;
        bus_if.idex_ready      = 1'b1;
        set_ex(1'b0, 2'd0, 8'h00);
        set_mem(1'b0, 2'd0, 8'h00);
`ifdef OPERAND_FETCH_STALL_CNT_EN
        cnt_clr = 1'b0;
`endif

        // Reset state
        #12;
        check_cleared("reset");
        check("reset.op_a", 16'(bus_if.idex_op_a), 16'd0);
        check("reset.op_b", 16'(bus_if.idex_op_b), 16'd0);
        check("reset.stall", 16'(bus_if.ifid_stall), 16'd0);
        rst_n = 1'b1;
        step();

        // EX wins over MEM
        drive(8'h26, 8'h05, 8'h33);
        set_ex(1'b1, 2'd2, 8'h11);
        set_mem(1'b1, 2'd2, 8'h22);
        push(4'h2, 2'd1, 2'd2, 8'h05, 8'h11);
        #1 check("fwd_prio.stall", 16'(bus_if.ifid_stall), 16'd0);
        step();
        expect_issue("fwd_prio");

        // MEM only
        set_ex(1'b0, 2'd2, 8'h11);
        push(4'h2, 2'd1, 2'd2, 8'h05, 8'h22);
        step();
        expect_issue("fwd_mem");

        // No bus matches (MEM targets R0)
        set_mem(1'b1, 2'd0, 8'h22);
        push(4'h2, 2'd1, 2'd2, 8'h05, 8'h33);
        step();
        expect_issue("fwd_none");
        set_mem(1'b0, 2'd0, 8'h00);

        // IN (7, ra=3) uses no source register: no hazard
        drive(8'h7E, 8'h00, 8'h00);
        bus_if.ex_load_pending = 1'b1;
        bus_if.ex_load_reg     = 2'd2;
        #1 check("in_nohaz.stall", 16'(bus_if.ifid_stall), 16'd0);
        // POP (7, ra=1) reads SP: load into SP is a hazard
        drive(8'h74, 8'h00, 8'h00);
        bus_if.ex_load_reg = 2'd3;
        #1 check("pop_sp_haz.stall", 16'(bus_if.ifid_stall), 16'd1);

        // Load-use: one bubble, then MEM-forwarded value
        drive(8'h26, 8'h05, 8'h33);
        bus_if.ex_load_reg = 2'd2;
        #1 check("ldu.stall", 16'(bus_if.ifid_stall), 16'd1);
        step();
        check_cleared("ldu.bubble");
        set_mem(1'b1, 2'd2, 8'h44);
        push(4'h2, 2'd1, 2'd2, 8'h05, 8'h44);
        #1 check("ldu.stall2", 16'(bus_if.ifid_stall), 16'd0);
        step();
        expect_issue("ldu.issue");
        bus_if.ex_load_pending = 1'b0;
        set_mem(1'b0, 2'd0, 8'h00);

        // PUSH R1: operand A comes from SP via EX forward
        drive(8'h71, 8'h99, 8'h12);
        set_ex(1'b1, 2'd3, 8'hFE);
        push(4'h7, 2'd0, 2'd1, 8'hFE, 8'h12);
        step();
        expect_issue("push");
        set_ex(1'b0, 2'd0, 8'h00);

        // Backpressure: IDEX holds the PUSH for 3 cycles
        bus_if.idex_ready = 1'b0;
        drive(8'h3B, 8'h01, 8'h02);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp.stall", 16'(bus_if.ifid_stall), 16'd1);
            step();
            check("bp.valid",  16'(bus_if.idex_valid),  16'd1);
            check("bp.opcode", 16'(bus_if.idex_opcode), 16'h7);
            check("bp.rb",     16'(bus_if.idex_rb),     16'd1);
            check("bp.op_a",   16'(bus_if.idex_op_a),   16'hFE);
            check("bp.op_b",   16'(bus_if.idex_op_b),   16'h12);
        end
        bus_if.idex_ready = 1'b1;
        push(4'h3, 2'd2, 2'd3, 8'h01, 8'h02);
        step();
        expect_issue("bp.release");

        // Flush during STALL
        drive(8'h26, 8'h05, 8'h33);
        bus_if.ex_load_pending = 1'b1;
        bus_if.ex_load_reg     = 2'd2;
        step();
        check_cleared("flush.bubble");
        bus_if.flush = 1'b1;
        #1 check("flush.stall", 16'(bus_if.ifid_stall), 16'd0);
        step();
        check_cleared("flush");
        bus_if.flush = 1'b0;
        // Back in RUN: the same hazard is detected again
        #1 check("flush.run_haz", 16'(bus_if.ifid_stall), 16'd1);
        bus_if.ex_load_pending = 1'b0;
        push(4'h2, 2'd1, 2'd2, 8'h05, 8'h33);
        step();
        expect_issue("flush.after");

`ifdef OPERAND_FETCH_STALL_CNT_EN
        check("cnt.stall", stall_cnt, 16'd2);
        check("cnt.bp",    bp_cnt,    16'd3);
`endif

        // Async reset mid-cycle while in STALL
        bus_if.ex_load_pending = 1'b1;
        step();
        check_cleared("rst.bubble");
        #2 rst_n = 1'b0;
        #1;
        check_cleared("rst.async");
        check("rst.op_a",  16'(bus_if.idex_op_a),  16'd0);
        check("rst.op_b",  16'(bus_if.idex_op_b),  16'd0);
        check("rst.stall", 16'(bus_if.ifid_stall), 16'd0);
        #1 rst_n = 1'b1;
        bus_if.ex_load_pending = 1'b0;
        drive(8'h5B, 8'h0A, 8'h0B);
        push(4'h5, 2'd2, 2'd3, 8'h0A, 8'h0B);
        step();
        expect_issue("rst.first");

        check("sb.empty", 16'(sb.size()), 16'd0);
        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-side consumer of the forwarding buses. Takes the IFID instruction and the asynchronous register-file read data.
- Selects the newest value of each source operand from three sources: the EX forward bus, the MEM forward bus, or the register file.
- Detects load-use hazards that forwarding cannot cover, inserts exactly one bubble for each, and registers the result into the IDEX pipeline register.
- Sits between the IF/ID register and the execute stage of the 8-bit Harvard pipeline.

Parameters:
- DATA_W, 8, operand/data width
- REG_AW, 2, register index width (4 registers; register 3 is SP)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifid_valid  in  1  IFID holds a real instruction
- ifid_instr  in  8  [7:4] opcode, [3:2] ra, [1:0] rb
- rf_ra_data  in  DATA_W  register-file read of the operand-A source register
- rf_rb_data  in  DATA_W  register-file read of rb
- fwd_ex_valid  in  1  EX forward bus valid
- fwd_ex_reg  in  REG_AW  EX forward destination register
- fwd_ex_data  in  DATA_W  EX forward data
- fwd_mem_valid  in  1  MEM forward bus valid
- fwd_mem_reg  in  REG_AW  MEM forward destination register
- fwd_mem_data  in  DATA_W  MEM forward data
- ex_load_pending  in  1  instruction now in EX reads data memory (LDD/POP)
- ex_load_reg  in  REG_AW  destination of that load
- flush  in  1  branch/interrupt flush
- idex_ready  in  1  execute stage accepts IDEX this cycle
- ifid_stall  out  1  hold PC and IFID (combinational)
- idex_valid  out  1  IDEX holds a real instruction
- idex_opcode  out  4  registered opcode
- idex_ra  out  REG_AW  registered ra
- idex_rb  out  REG_AW  registered rb
- idex_op_a  out  DATA_W  registered resolved operand A
- idex_op_b  out  DATA_W  registered resolved operand B

Behaviour:
- Operand A source register (src_a):
  - ra normally.
  - Forced to 3 (SP) for opcode 7 with ra=0 (PUSH) and opcode 7 with ra=1 (POP).
  - The register file is addressed with src_a externally.
- uses_a = 1 for opcodes 2,3,4,5,A,D,E and for PUSH/POP; 0 otherwise.
- uses_b = 1 for every opcode except 0 (NOP), C (LDM), and 7 with ra=3 (IN).
- Operand resolution, per source register R (combinational):
  - if fwd_ex_valid and fwd_ex_reg==R, use fwd_ex_data;
  - else if fwd_mem_valid and fwd_mem_reg==R, use fwd_mem_data;
  - else use the rf data.
  - EX always wins when both buses match.
- Load-use hazard, combinational:
  - haz = ifid_valid & ex_load_pending & state==RUN & ((uses_a & ex_load_reg==src_a) | (uses_b & ex_load_reg==rb)).
- advance = idex_ready | ~idex_valid.
- ifid_stall = haz | ~advance.
- FSM, states RUN and STALL:
  - RUN, haz & advance: load a bubble (idex_valid←0), state←STALL.
  - RUN, no haz & advance: load IFID into IDEX with resolved operands; idex_valid←ifid_valid.
  - STALL: the hazard check is suppressed. The load is now in MEM and its value arrives on the MEM forward bus.
    - If advance: load IFID normally, state←RUN.
    - If not advance: stay in STALL.
  - Guarantees at most one bubble per load-use.
- ~advance: IDEX holds every field unchanged; state holds.
- flush:
  - Overrides everything: next edge sets idex_valid←0 and state←RUN.
  - ifid_stall is forced to 0 while flush is high.
  - Data fields are don't-care.
- Bubble or flush: idex_opcode, idex_ra and idex_rb are written as 0 (NOP encoding).
- Reset (rst_n low, asynchronous):
  - idex_valid=0, idex_opcode=0, idex_ra=0, idex_rb=0, idex_op_a=0, idex_op_b=0, state=RUN.
  - ifid_stall evaluates to 0.
  - Reset asserted mid-stall discards the pending bubble and the instruction.
- Latency: one cycle from IFID to IDEX when there is no hazard; two cycles with a load-use hazard.

Optional Feature:
- Macro OPERAND_FETCH_STALL_CNT_EN.
- Defined:
  - Adds outputs stall_cnt (16 bits), a saturating count of load-use bubbles inserted, and bp_cnt (16 bits), a saturating count of cycles with ~advance.
  - Both counters reset to 0, saturate at 16'hFFFF, and are cleared synchronously by input cnt_clr (1 bit).
- Undefined: these ports and the counter logic do not exist; behaviour is otherwise identical.

Test Plan:
- Forward priority: ADD R1,R2 (8'h26), fwd_ex={1,R2,8'h11}, fwd_mem={1,R2,8'h22}, rf_rb=8'h33, rf_ra=8'h05 → next edge idex_valid=1, op_a=8'h05, op_b=8'h11.
- MEM-only match: same instruction, fwd_ex_valid=0, fwd_mem={1,R2,8'h22} → op_b=8'h22; with neither bus matching → op_b=8'h33.
- Load-use: ex_load_pending=1, ex_load_reg=R2, IFID=8'h26 → ifid_stall=1 for exactly one cycle and one bubble (idex_valid=0). Next cycle fwd_mem={1,R2,8'h44} → idex_op_b=8'h44, idex_valid=1.
- PUSH R1 (8'h71) with fwd_ex={1,3,8'hFE} → op_a=8'hFE, taken from SP regardless of ra.
- Backpressure: idex_valid=1, idex_ready=0 for 3 cycles → IDEX fields constant and ifid_stall=1 for all 3 cycles. Assert flush during a STALL cycle → idex_valid=0 and state returns to RUN.
- Asynchronous reset pulsed mid-cycle during STALL → all outputs 0 immediately; the first post-reset instruction issues with no bubble.
